// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: request/response handshake with the
// execute stage plus the word-wide data memory bus.
// master = the load/store unit itself, slave = execute stage + memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wd
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for the shared data memory bus.
// Loads read one word and extract/extend a lane; sub-word stores do a
// read-modify-write so neighbouring bytes survive; word stores write directly.
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned H/W accesses are
// rejected with resp_err; otherwise they are snapped to natural alignment.
module load_store_unit #(
   parameter logic [15:0] RAM_LO = 16'h0010,
   parameter logic [15:0] RAM_HI = 16'hFF0F
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_ADDR, RMW_DATA, RMW_WR, RESP
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wd_q, mem_wd_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        req_legal;
   logic        accept;

   // Byte lane actually used: halfwords snap to addr[1], words to lane 0
   function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   lane_offset = a;
         2'b01:   lane_offset = {a[1], 1'b0};
         default: lane_offset = 2'b00;
      endcase
   endfunction

   // Pull the addressed lane down to bit 0 and sign/zero extend it
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_extract = {24'h0, sh[7:0]};
         3'b101:  load_extract = {16'h0, sh[15:0]};
         default: load_extract = sh;
      endcase
   endfunction

   // Replace the selected byte or halfword lane of the old word, keep the rest
   function automatic logic [31:0] store_merge(input logic half, input logic [1:0] off,
                                               input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] mask;
      mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << {off, 3'b000};
      store_merge = (old & ~mask) | ((wd << {off, 3'b000}) & mask);
   endfunction

   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign accept         = bus.req_valid && bus.req_ready;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wd     = mem_wd_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

   // Decide at accept time whether the incoming request may touch the bus
   always_comb begin
      req_legal = 1'b1;
      if (bus.req_store) begin
         if (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11)) req_legal = 1'b0;
         if ((bus.req_addr[31:16] < RAM_LO) || (bus.req_addr[31:16] > RAM_HI)) req_legal = 1'b0;
      end else begin
         if ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11)) req_legal = 1'b0;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) req_legal = 1'b0;
      if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) req_legal = 1'b0;
`endif
   end

   // Next-state and registered-output logic for the transaction sequencer
   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      funct3_d     = funct3_q;
      wdata_d      = wdata_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wd_d     = mem_wd_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               off_d    = lane_offset(bus.req_funct3, bus.req_addr[1:0]);
               funct3_d = bus.req_funct3;
               wdata_d  = bus.req_wdata;
               if (!req_legal) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_addr_d = {bus.req_addr[31:2], 2'b00};
                  if (!bus.req_store) begin
                     state_d = LD_ADDR;
                  end else if (bus.req_funct3[1:0] == 2'b10) begin
                     state_d  = ST_WR;
                     mem_we_d = 1'b1;
                     mem_wd_d = bus.req_wdata;
                  end else begin
                     state_d = RMW_ADDR;
                  end
               end
            end
         end
         LD_ADDR:  state_d = LD_DATA;
         LD_DATA: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_extract(funct3_q, off_q, bus.mem_rd);
         end
         ST_WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RMW_ADDR: state_d = RMW_DATA;
         RMW_DATA: begin
            state_d  = RMW_WR;
            mem_we_d = 1'b1;
            mem_wd_d = store_merge(funct3_q[0], off_q, bus.mem_rd, wdata_q);
         end
         RMW_WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         off_q        <= 2'b00;
         funct3_q     <= 3'b000;
         wdata_q      <= 32'h0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wd_q     <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         funct3_q     <= funct3_d;
         wdata_q      <= wdata_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wd_q     <= mem_wd_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule
